// File: rtl/nc_fetch_responder.sv
// Memory-side responder for NC instruction fetches: reads NUM_DW doublewords critical-first and returns one 256-bit line.
// Optional RSP-wait timeout with late-response drain is enabled by defining NC_FETCH_TIMEOUT_EN.
module nc_fetch_responder #(
    parameter int NUM_DW         = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_nc_valid_i,
    input  logic [39:0]  req_nc_vaddr_i,
    output logic         l2_grant_valid_o,
    output logic [255:0] l2_resp_data_o,
    output logic         mem_req_valid_o,
    input  logic         mem_req_ready_i,
    output logic [39:0]  mem_req_addr_o,
    input  logic         mem_rsp_valid_i,
    input  logic [63:0]  mem_rsp_data_i,
    output logic         busy_o,
    output logic         drop_o,
    output logic         timeout_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP, ST_GRANT} state_t;

    localparam logic [1:0] LAST_CNT = 2'(NUM_DW - 1);

    state_t         state_q;
    logic [34:0]    base_q;
    logic [1:0]     dw0_q;
    logic [1:0]     cnt_q;
    logic [255:0]   line_q;
    logic           grant_q;
    logic           drop_q;
    logic           timeout_q;
    logic           mem_req_valid_q;
    logic [39:0]    mem_req_addr_q;
    logic           rsp_take;
    logic           tout_hit;
    logic           unused_vaddr_bits;

    assign unused_vaddr_bits = ^req_nc_vaddr_i[2:0];

`ifdef NC_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] wait_q;
    logic          drain_q;

    // A pending drain swallows the next response wherever the FSM is.
    assign rsp_take = mem_rsp_valid_i && !drain_q;
    assign tout_hit = (state_q == ST_RSP) && !mem_rsp_valid_i &&
                      (wait_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_q  <= '0;
            drain_q <= 1'b0;
        end else begin
            if (state_q != ST_RSP) begin
                wait_q <= '0;
            end else if (!mem_rsp_valid_i) begin
                wait_q <= wait_q + 1'b1;
            end
            if (tout_hit) begin
                drain_q <= 1'b1;
            end else if (drain_q && mem_rsp_valid_i) begin
                drain_q <= 1'b0;
            end
        end
    end
`else
    assign rsp_take = mem_rsp_valid_i;
    assign tout_hit = 1'b0;
`endif

    // Handshake: mem_req_valid_o and mem_req_addr_o stay constant from assertion until the
    // cycle mem_req_ready_i is seen high; the beat transfers on that valid&ready cycle only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            base_q          <= '0;
            dw0_q           <= '0;
            cnt_q           <= '0;
            line_q          <= '0;
            grant_q         <= 1'b0;
            drop_q          <= 1'b0;
            timeout_q       <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            grant_q   <= 1'b0;
            timeout_q <= 1'b0;
            drop_q    <= req_nc_valid_i && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (req_nc_valid_i) begin
                        base_q          <= req_nc_vaddr_i[39:5];
                        dw0_q           <= req_nc_vaddr_i[4:3];
                        cnt_q           <= '0;
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= {req_nc_vaddr_i[39:3], 3'b000};
                        state_q         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_take) begin
                        // The first capture also clears the stale line, so the previous
                        // response stays visible until new data arrives.
                        if (cnt_q == 2'd0) begin
                            line_q <= {192'b0, mem_rsp_data_i};
                        end else begin
                            line_q[{cnt_q, 6'b0} +: 64] <= mem_rsp_data_i;
                        end
                        if (cnt_q == LAST_CNT) begin
                            grant_q <= 1'b1;
                            state_q <= ST_GRANT;
                        end else begin
                            cnt_q           <= cnt_q + 2'd1;
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= {base_q, dw0_q + cnt_q + 2'd1, 3'b000};
                            state_q         <= ST_REQ;
                        end
                    end else if (tout_hit) begin
                        line_q    <= '0;
                        grant_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign l2_grant_valid_o = grant_q;
    assign l2_resp_data_o   = line_q;
    assign mem_req_valid_o  = mem_req_valid_q;
    assign mem_req_addr_o   = mem_req_addr_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign drop_o           = drop_q;
    assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_nc_fetch_responder.sv
// Bench for nc_fetch_responder: one NUM_DW=4 and one NUM_DW=1 instance, each with its own memory model.
// The timeout scenario runs only when NC_FETCH_TIMEOUT_EN is defined.
module tb_nc_fetch_responder;

    localparam int TO_CYC     = 16;
    localparam int LATE_DELAY = 24;
    localparam int BUDGET     = 400;

    typedef struct packed {
        logic [39:0] addr;
        int          due;
    } pend_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic         req_v      [2];
    logic [39:0]  req_addr   [2];
    logic         grant_a    [2];
    logic [255:0] resp_a     [2];
    logic         mem_req_v  [2];
    logic         mem_ready_a[2];
    logic [39:0]  mem_req_a  [2];
    logic         mem_rsp_v  [2];
    logic [63:0]  mem_rsp_d  [2];
    logic         busy_a     [2];
    logic         drop_a     [2];
    logic         tout_a     [2];

    pend_t        pend_q     [2][$];
    int           stall_beat [2];
    int           stall_len  [2];
    int           stall_left [2];
    int           lost_beat  [2];
    int           beat_n     [2];
    bit           rnd_mode   [2];
    bit           beat_open  [2];
    logic [39:0]  held_addr  [2];
    logic [39:0]  beat_log   [2][8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nc_fetch_responder #(.NUM_DW(4), .TIMEOUT_CYCLES(TO_CYC)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .req_nc_valid_i(req_v[0]), .req_nc_vaddr_i(req_addr[0]),
        .l2_grant_valid_o(grant_a[0]), .l2_resp_data_o(resp_a[0]),
        .mem_req_valid_o(mem_req_v[0]), .mem_req_ready_i(mem_ready_a[0]),
        .mem_req_addr_o(mem_req_a[0]), .mem_rsp_valid_i(mem_rsp_v[0]),
        .mem_rsp_data_i(mem_rsp_d[0]), .busy_o(busy_a[0]),
        .drop_o(drop_a[0]), .timeout_o(tout_a[0])
    );

    nc_fetch_responder #(.NUM_DW(1), .TIMEOUT_CYCLES(TO_CYC)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_nc_valid_i(req_v[1]), .req_nc_vaddr_i(req_addr[1]),
        .l2_grant_valid_o(grant_a[1]), .l2_resp_data_o(resp_a[1]),
        .mem_req_valid_o(mem_req_v[1]), .mem_req_ready_i(mem_ready_a[1]),
        .mem_req_addr_o(mem_req_a[1]), .mem_rsp_valid_i(mem_rsp_v[1]),
        .mem_rsp_data_i(mem_rsp_d[1]), .busy_o(busy_a[1]),
        .drop_o(drop_a[1]), .timeout_o(tout_a[1])
    );

    // Memory contents: a fixed function of the doubleword address.
    function automatic logic [63:0] mem_dw(input logic [39:0] a);
        return {a[31:0] ^ 32'h5A5A_C3C3, a[39:8]};
    endfunction

    // Address of the k-th doubleword returned: critical DW first, wrapping inside the 32B line.
    function automatic logic [39:0] beat_addr(input logic [39:0] a, input int k);
        logic [39:0] line_base;
        int          off;
        line_base = a & ~40'h1F;
        off       = (int'(a[4:3]) + k) % 4;
        return line_base + 40'(off * 8);
    endfunction

    // Memory model, evaluated at every falling edge: returns beats in order, applies stalls.
    task automatic mem_step(input int i);
        pend_t e;
        mem_rsp_v[i]   = 1'b0;
        mem_ready_a[i] = 1'b0;
        if (rst) begin
            pend_q[i].delete();
            beat_open[i]  = 1'b0;
            stall_left[i] = 0;
            return;
        end
        if (pend_q[i].size() > 0 && pend_q[i][0].due <= cyc) begin
            mem_rsp_v[i] = 1'b1;
            mem_rsp_d[i] = mem_dw(pend_q[i][0].addr);
            void'(pend_q[i].pop_front());
        end
        if (beat_open[i]) begin
            tests_run++;
            if (!mem_req_v[i] || mem_req_a[i] !== held_addr[i]) begin
                tests_failed++;
                $display("FAIL req_stable[%0d]: valid=%0b addr=%h required valid=1 addr=%h",
                         i, mem_req_v[i], mem_req_a[i], held_addr[i]);
                if (!mem_req_v[i]) beat_open[i] = 1'b0;
            end
        end else if (mem_req_v[i]) begin
            beat_open[i] = 1'b1;
            held_addr[i] = mem_req_a[i];
            if (beat_n[i] == stall_beat[i]) stall_left[i] = stall_len[i];
            else if (rnd_mode[i])           stall_left[i] = $urandom_range(0, 3);
            else                            stall_left[i] = 0;
        end
        if (beat_open[i] && mem_req_v[i]) begin
            if (stall_left[i] > 0) begin
                stall_left[i]--;
            end else begin
                mem_ready_a[i] = 1'b1;
                e.addr = mem_req_a[i];
                e.due  = cyc + 1;
                if (beat_n[i] == lost_beat[i]) e.due = e.due + LATE_DELAY;
                else if (rnd_mode[i])           e.due = e.due + $urandom_range(0, 3);
                pend_q[i].push_back(e);
                if (beat_n[i] < 8) beat_log[i][beat_n[i]] = mem_req_a[i];
                beat_n[i]++;
                beat_open[i] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        mem_step(0);
        mem_step(1);
    end

    // One request on instance i; checks grant count, latency, line, timeout flag, beat addresses, drops.
    task automatic run_txn(input int i, input logic [39:0] addr, input int exp_lat,
                           input int extra, input bit exp_tout, input string name);
        int           ndw, nbeats, n, g_cnt, g_cyc, d_cnt;
        logic [255:0] g_data, exp_data;
        logic         g_tout;
        bit           done;
        ndw      = (i == 0) ? 4 : 1;
        nbeats   = exp_tout ? lost_beat[i] + 1 : ndw;
        exp_data = '0;
        if (!exp_tout)
            for (int k = 0; k < ndw; k++) exp_data[64*k +: 64] = mem_dw(beat_addr(addr, k));
        beat_n[i] = 0;
        g_cnt = 0; g_cyc = 0; d_cnt = 0; g_data = '0; g_tout = 1'b0;
        req_addr[i] = addr;
        req_v[i]    = 1'b1;
        n = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            n++;
            req_v[i] = (n == extra);
            if (n == extra) req_addr[i] = addr ^ 40'h00_0000_0460;
            if (grant_a[i]) begin
                g_cnt++;
                if (g_cnt == 1) begin
                    g_cyc  = n;
                    g_data = resp_a[i];
                    g_tout = tout_a[i];
                end
            end
            if (drop_a[i]) d_cnt++;
            if (g_cnt > 0 && n >= g_cyc + 1 && n > extra) done = 1'b1;
            if (n >= BUDGET) done = 1'b1;
        end
        req_v[i] = 1'b0;

        tests_run++;
        if (g_cnt !== 1) begin
            tests_failed++;
            $display("FAIL %s_grant_count: got %0d grants in %0d cycles, required 1", name, g_cnt, n);
        end
        if (exp_lat >= 0) begin
            tests_run++;
            if (g_cyc !== exp_lat) begin
                tests_failed++;
                $display("FAIL %s_latency: grant in cycle %0d, required %0d", name, g_cyc, exp_lat);
            end
        end
        tests_run++;
        if (g_data !== exp_data) begin
            tests_failed++;
            $display("FAIL %s_data: got %h required %h", name, g_data, exp_data);
        end
        tests_run++;
        if (g_tout !== exp_tout) begin
            tests_failed++;
            $display("FAIL %s_timeout_flag: got %0b required %0b", name, g_tout, exp_tout);
        end
        tests_run++;
        if (beat_n[i] !== nbeats) begin
            tests_failed++;
            $display("FAIL %s_beat_count: got %0d required %0d", name, beat_n[i], nbeats);
        end
        for (int k = 0; k < nbeats && k < beat_n[i]; k++) begin
            tests_run++;
            if (beat_log[i][k] !== beat_addr(addr, k)) begin
                tests_failed++;
                $display("FAIL %s_beat_addr%0d: got %h required %h", name, k, beat_log[i][k],
                         beat_addr(addr, k));
            end
        end
        tests_run++;
        if (d_cnt !== ((extra > 0) ? 1 : 0)) begin
            tests_failed++;
            $display("FAIL %s_drop_count: got %0d required %0d", name, d_cnt, (extra > 0) ? 1 : 0);
        end
        tests_run++;
        if (busy_a[i] !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle_after: busy=%0b required 0", name, busy_a[i]);
        end
    endtask

    task automatic check_outputs_zero(input int i, input string name);
        tests_run++;
        if (grant_a[i] !== 1'b0 || resp_a[i] !== '0 || mem_req_v[i] !== 1'b0 ||
            mem_req_a[i] !== '0 || busy_a[i] !== 1'b0 || drop_a[i] !== 1'b0 || tout_a[i] !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s[%0d]: grant=%0b data=%h mreq=%0b maddr=%h busy=%0b drop=%0b tout=%0b required all 0",
                     name, i, grant_a[i], resp_a[i], mem_req_v[i], mem_req_a[i], busy_a[i],
                     drop_a[i], tout_a[i]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero(0, "reset");
        check_outputs_zero(1, "reset");
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero(0, "post_reset");
        check_outputs_zero(1, "post_reset");
    endtask

    task automatic test_critical_first();
        run_txn(0, 40'h00_0000_1008, 9, 0, 1'b0, "t1_crit_wrap");
        run_txn(0, 40'h12_3456_7800, 9, 0, 1'b0, "aligned_line");
        run_txn(0, 40'hFF_FFFF_FFF8, 9, 0, 1'b0, "top_addr_wrap");
    endtask

    task automatic test_single_dw();
        run_txn(1, 40'h00_0000_1018, 3, 0, 1'b0, "t2_single_dw");
        run_txn(1, 40'h0A_BCDE_F007, 3, 0, 1'b0, "single_dw_low_bits");
    endtask

    task automatic test_ready_stall();
        stall_beat[0] = 1;
        stall_len[0]  = 5;
        run_txn(0, 40'h00_0000_1008, 14, 0, 1'b0, "t3_ready_stall");
        stall_beat[0] = -1;
    endtask

    task automatic test_drop();
        run_txn(0, 40'h00_0000_5010, 9, 2, 1'b0, "t4_drop_in_rsp");
        run_txn(0, 40'h00_0000_6018, 9, 9, 1'b0, "drop_in_grant");
        run_txn(1, 40'h00_0000_7008, 3, 3, 1'b0, "drop_in_grant_dw1");
    endtask

    task automatic test_random();
        logic [39:0] a;
        rnd_mode[0] = 1'b1;
        rnd_mode[1] = 1'b1;
        for (int t = 0; t < 16; t++) begin
            a = {8'($urandom), 32'($urandom)};
            run_txn(t % 2, a, -1, 0, 1'b0, "random");
        end
        rnd_mode[0] = 1'b0;
        rnd_mode[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [39:0] a;
        for (int t = 0; t < 6; t++) begin
            a = {8'($urandom), 32'($urandom)};
            run_txn((t < 4) ? 0 : 1, a, (t < 4) ? 9 : 3, 0, 1'b0, "back_to_back");
        end
    endtask

    task automatic test_reset_mid();
        int g_cnt;
        req_addr[0] = 40'h00_0000_2010;
        req_v[0]    = 1'b1;
        g_cnt       = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            req_v[0] = 1'b0;
            if (n == 2) rst = 1'b1;
            if (n == 3) check_outputs_zero(0, "t6_reset_in_rsp");
            if (n == 4) rst = 1'b0;
            if (grant_a[0]) g_cnt++;
        end
        tests_run++;
        if (g_cnt !== 0) begin
            tests_failed++;
            $display("FAIL t6_no_grant: got %0d grants, required 0", g_cnt);
        end
        run_txn(0, 40'h00_0000_2010, 9, 0, 1'b0, "t6_fresh_after_reset");
    endtask

`ifdef NC_FETCH_TIMEOUT_EN
    task automatic test_timeout();
        lost_beat[0] = 2;
        run_txn(0, 40'h00_0000_3010, 2 * 2 + 2 + TO_CYC, 0, 1'b1, "t5_timeout");
        lost_beat[0] = -1;
        run_txn(0, 40'h00_0000_4008, -1, 0, 1'b0, "t5_after_drain");
        run_txn(0, 40'h00_0000_4818, 9, 0, 1'b0, "t5_clean_after_drain");
    endtask
`endif

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_v[i]       = 1'b0;
            req_addr[i]    = '0;
            mem_ready_a[i] = 1'b0;
            mem_rsp_v[i]   = 1'b0;
            mem_rsp_d[i]   = '0;
            stall_beat[i]  = -1;
            stall_len[i]   = 0;
            stall_left[i]  = 0;
            lost_beat[i]   = -1;
            beat_n[i]      = 0;
            rnd_mode[i]    = 1'b0;
            beat_open[i]   = 1'b0;
            held_addr[i]   = '0;
        end
        test_reset();
        test_critical_first();
        test_single_dw();
        test_ready_stall();
        test_drop();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef NC_FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
